// File: rtl/clb_param_pkg.sv
// rtl/clb_param_pkg.sv - shared types and geometry helpers for the parametrised CLB tile
// CLB_CFG_PARITY_EN adds one parity bit to the configuration frame.
package clb_param_pkg;

   typedef enum logic [1:0] {
      UNCONF = 2'd0,
      SHIFT  = 2'd1,
      ACTIVE = 2'd2,
      ERR    = 2'd3
   } state_t;

   function automatic int sel_w(input int num_i, input int num_ble);
      return $clog2(num_i + num_ble);
   endfunction

   function automatic int ble_bits(input int k, input int selw);
      return (2 ** k) + k * selw + 1;
   endfunction

   function automatic int cfg_bits(input int num_ble, input int bb);
`ifdef CLB_CFG_PARITY_EN
      return num_ble * bb + 1;
`else
      return num_ble * bb;
`endif
   endfunction

endpackage

// File: rtl/clb_tile_param_if.sv
// rtl/clb_tile_param_if.sv - user and configuration-chain signals of one CLB tile
interface clb_tile_param_if #(
   parameter int NUM_I   = 12,
   parameter int NUM_BLE = 4
);
   logic               set;
   logic               prog_en;
   logic               ccff_head;
   logic               ccff_tail;
   logic [NUM_I-1:0]   I;
   logic [NUM_BLE-1:0] O;
   logic               cfg_done;
   logic               cfg_err;

   modport master (
      output set, prog_en, ccff_head, I,
      input  ccff_tail, O, cfg_done, cfg_err
   );

   modport slave (
      input  set, prog_en, ccff_head, I,
      output ccff_tail, O, cfg_done, cfg_err
   );
endinterface

// File: rtl/clb_ble.sv
// rtl/clb_ble.sv - one basic logic element: input crossbar, K-LUT, FF and output select
module clb_ble
   import clb_param_pkg::*;
#(
   parameter int NUM_I    = 12,
   parameter int NUM_BLE  = 4,
   parameter int K        = 4,
   parameter int SEL_W    = sel_w(NUM_I, NUM_BLE),
   parameter int BLE_BITS = ble_bits(K, SEL_W)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                active,
   input  logic                set,
   input  logic [NUM_I-1:0]    I,
   input  logic [NUM_BLE-1:0]  q_all,
   input  logic [BLE_BITS-1:0] cfg,
   output logic                q,
   output logic                o
);
   localparam int SRC_W = 2 ** SEL_W;

   logic [2**K-1:0] lut;
   logic            mode;
   logic [SRC_W-1:0] src;
   logic [K-1:0]    lut_in;
   logic            f;

   assign lut  = cfg[2**K-1:0];
   assign mode = cfg[BLE_BITS-1];

   // Select codes past the last real source read the zero padding.
   always_comb begin
      src                  = '0;
      src[NUM_I-1:0]       = I;
      src[NUM_I +: NUM_BLE] = q_all;
   end

   always_comb begin
      lut_in = '0;
      for (int i = 0; i < K; i++) begin
         lut_in[i] = src[cfg[2**K + i*SEL_W +: SEL_W]];
      end
   end

   assign f = lut[lut_in];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else if (active) begin
         q <= set | f;
      end else begin
         q <= 1'b0;
      end
   end

   assign o = active & (mode ? q : f);
endmodule

// File: rtl/clb_tile_param.sv
// rtl/clb_tile_param.sv - CLB tile top: config shift chain, bit counter, load FSM, BLE array
// CLB_CFG_PARITY_EN enables frame parity checking and the ERR state.
module clb_tile_param
   import clb_param_pkg::*;
#(
   parameter int NUM_I   = 12,
   parameter int NUM_BLE = 4,
   parameter int K       = 4
) (
   input logic              clk,
   input logic              reset,
   clb_tile_param_if.slave  bus
);
   localparam int SEL_W    = sel_w(NUM_I, NUM_BLE);
   localparam int BLE_BITS = ble_bits(K, SEL_W);
   localparam int CFG_BITS = cfg_bits(NUM_BLE, BLE_BITS);
   localparam int CNT_W    = $clog2(CFG_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

   state_t              state, state_nx;
   logic [CFG_BITS-1:0] cfg_q;
   logic [CNT_W-1:0]    cnt;
   logic                parity_ok;
   logic                active;
   logic                done_w;
   logic                err_w;
   logic [NUM_BLE-1:0]  q;
   logic [NUM_BLE-1:0]  o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_q <= '0;
      end else if (bus.prog_en) begin
         cfg_q <= {cfg_q[CFG_BITS-2:0], bus.ccff_head};
      end
   end

   // Entering SHIFT restarts the count with the bit shifted on that same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (bus.prog_en) begin
         if (state != SHIFT) begin
            cnt <= CNT_W'(1);
         end else if (cnt != CNT_FULL) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef CLB_CFG_PARITY_EN
   assign parity_ok = ~^cfg_q;
`else
   assign parity_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= UNCONF;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         UNCONF: if (bus.prog_en) state_nx = SHIFT;
         SHIFT: begin
            if (!bus.prog_en) begin
               if (cnt != CNT_FULL) begin
                  state_nx = UNCONF;
               end else if (parity_ok) begin
                  state_nx = ACTIVE;
               end else begin
                  state_nx = ERR;
               end
            end
         end
         ACTIVE:  if (bus.prog_en) state_nx = SHIFT;
         ERR:     if (bus.prog_en) state_nx = SHIFT;
         default: state_nx = UNCONF;
      endcase
   end

   always_comb begin
      active = 1'b0;
      done_w = 1'b0;
      err_w  = 1'b0;
      case (state)
         ACTIVE: begin
            active = 1'b1;
            done_w = 1'b1;
         end
         ERR:     err_w = 1'b1;
         default: ;
      endcase
   end

   for (genvar b = 0; b < NUM_BLE; b++) begin : g_ble
      clb_ble #(
         .NUM_I    (NUM_I),
         .NUM_BLE  (NUM_BLE),
         .K        (K),
         .SEL_W    (SEL_W),
         .BLE_BITS (BLE_BITS)
      ) u_ble (
         .clk    (clk),
         .reset  (reset),
         .active (active),
         .set    (bus.set),
         .I      (bus.I),
         .q_all  (q),
         .cfg    (cfg_q[b*BLE_BITS +: BLE_BITS]),
         .q      (q[b]),
         .o      (o[b])
      );
   end

   assign bus.O         = o;
   assign bus.ccff_tail = cfg_q[CFG_BITS-1];
   assign bus.cfg_done  = done_w;
`ifdef CLB_CFG_PARITY_EN
   assign bus.cfg_err   = err_w;
`else
   assign bus.cfg_err   = 1'b0;
`endif
endmodule

// File: tb/tb_clb_tile_param.sv
// tb/tb_clb_tile_param.sv - directed self-checking bench for clb_tile_param
module tb_clb_tile_param;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clb_tile_param_if #(.NUM_I(12), .NUM_BLE(4)) bus ();

   clb_tile_param #(.NUM_I(12), .NUM_BLE(4), .K(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

`ifdef CLB_CFG_PARITY_EN
   localparam int CFG = 133;
`else
   localparam int CFG = 132;
`endif

   // BLE word = {mode, sel3, sel2, sel1, sel0, lut}
   localparam logic [32:0] B_AND4 = {1'b0, 4'd3, 4'd2, 4'd1, 4'd0, 16'h8000};
   localparam logic [32:0] B_IDLE = {1'b0, 4'd15, 4'd15, 4'd15, 4'd15, 16'h0000};
   localparam logic [32:0] B_TOG  = {1'b1, 4'd15, 4'd15, 4'd15, 4'd13, 16'h5555};

   int passed = 0;
   int total  = 0;
   logic [147:0] frame_a;
   logic [147:0] frame_b;

   function automatic logic [147:0] mk_frame(input logic [32:0] b0, input logic [32:0] b1,
                                              input logic [32:0] b2, input logic [32:0] b3);
      logic [147:0] f;
      f = '0;
      f[131:0] = {b3, b2, b1, b0};
`ifdef CLB_CFG_PARITY_EN
      f[132] = ^f[131:0];
`endif
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input logic [147:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         bus.prog_en   = 1'b1;
         bus.ccff_head = v[i];
         tick();
      end
      bus.prog_en   = 1'b0;
      bus.ccff_head = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.set = 1'b0; bus.prog_en = 1'b0; bus.ccff_head = 1'b0; bus.I = '1;
      tick(); tick();
      total++; if (bus.O !== 4'b0) $display("FAIL reset_o got=%b exp=0000", bus.O); else passed++;
      total++; if (bus.ccff_tail !== 1'b0) $display("FAIL reset_tail got=%b exp=0", bus.ccff_tail); else passed++;
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.cfg_done); else passed++;
      total++; if (bus.cfg_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.cfg_err); else passed++;
      reset = 1'b0;
      tick();
      total++; if (bus.O !== 4'b0) $display("FAIL unconf_o got=%b exp=0000", bus.O); else passed++;
   endtask

   task automatic test_comb_lut();
      bus.I = '0;
      shift_bits(frame_a, CFG);
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL shift_done got=%b exp=0", bus.cfg_done); else passed++;
      tick();
      total++; if (bus.cfg_done !== 1'b1) $display("FAIL load_done got=%b exp=1", bus.cfg_done); else passed++;
      total++; if (bus.cfg_err !== 1'b0) $display("FAIL load_err got=%b exp=0", bus.cfg_err); else passed++;
      bus.I = 12'h00F; #1;
      total++; if (bus.O !== 4'b0001) $display("FAIL and4_f got=%b exp=0001", bus.O); else passed++;
      bus.I = 12'h007; #1;
      total++; if (bus.O !== 4'b0000) $display("FAIL and4_7 got=%b exp=0000", bus.O); else passed++;
      bus.I = 12'hFFF; #1;
      total++; if (bus.O !== 4'b0001) $display("FAIL and4_fff got=%b exp=0001", bus.O); else passed++;
      bus.I = 12'h00E; #1;
      total++; if (bus.O !== 4'b0000) $display("FAIL and4_e got=%b exp=0000", bus.O); else passed++;
   endtask

   task automatic test_reg_toggle();
      bus.I = '0;
      shift_bits(frame_b, CFG);
      tick();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (bus.O !== {2'b00, 1'(k % 2), 1'b0})
            $display("FAIL toggle_%0d got=%b exp=%b", k, bus.O, {2'b00, 1'(k % 2), 1'b0});
         else passed++;
         if (k < 3) tick();
      end
      bus.set = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++; if (bus.O !== 4'b0010) $display("FAIL set_hold_%0d got=%b exp=0010", k, bus.O); else passed++;
      end
      bus.set = 1'b0;
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; #1;
      total++; if (bus.O !== 4'b0) $display("FAIL midrst_o got=%b exp=0000", bus.O); else passed++;
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", bus.cfg_done); else passed++;
      total++; if (bus.ccff_tail !== 1'b0) $display("FAIL midrst_tail got=%b exp=0", bus.ccff_tail); else passed++;
      reset = 1'b0;
      tick();
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL midrst_after got=%b exp=0", bus.cfg_done); else passed++;
   endtask

   task automatic test_partial();
      shift_bits(frame_a, CFG);
      tick();
      total++; if (bus.cfg_done !== 1'b1) $display("FAIL part_pre got=%b exp=1", bus.cfg_done); else passed++;
      shift_bits(frame_a, 100);
      tick();
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL part_done got=%b exp=0", bus.cfg_done); else passed++;
      bus.I = 12'hFFF; #1;
      total++; if (bus.O !== 4'b0) $display("FAIL part_o_fff got=%b exp=0000", bus.O); else passed++;
      bus.I = 12'h00F; #1;
      total++; if (bus.O !== 4'b0) $display("FAIL part_o_f got=%b exp=0000", bus.O); else passed++;
   endtask

   task automatic test_passthrough();
      logic [147:0] v;
      v = '0;
      v[CFG-1:0]     = frame_a[CFG-1:0];
      v[CFG +: 8]    = 8'b1011_0010;
      for (int n = 0; n < CFG + 8; n++) begin
         bus.prog_en   = 1'b1;
         bus.ccff_head = v[CFG + 7 - n];
         if (n >= CFG) begin
            total++;
            if (bus.ccff_tail !== v[2*CFG + 7 - n])
               $display("FAIL tail_%0d got=%b exp=%b", n, bus.ccff_tail, v[2*CFG + 7 - n]);
            else passed++;
         end
         tick();
      end
      bus.prog_en = 1'b0;
      tick();
      total++; if (bus.cfg_done !== 1'b1) $display("FAIL long_done got=%b exp=1", bus.cfg_done); else passed++;
      bus.I = 12'h00F; #1;
      total++; if (bus.O !== 4'b0001) $display("FAIL long_cfg got=%b exp=0001", bus.O); else passed++;
      bus.prog_en = 1'b1;
      tick();
      total++; if (bus.O !== 4'b0) $display("FAIL reprog_o got=%b exp=0000", bus.O); else passed++;
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL reprog_done got=%b exp=0", bus.cfg_done); else passed++;
      bus.prog_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_shift60();
      for (int n = 0; n < 60; n++) begin
         bus.prog_en   = 1'b1;
         bus.ccff_head = 1'b1;
         tick();
      end
      reset = 1'b1; #1;
      total++; if (bus.ccff_tail !== 1'b0) $display("FAIL rst60_tail got=%b exp=0", bus.ccff_tail); else passed++;
      total++; if (bus.O !== 4'b0) $display("FAIL rst60_o got=%b exp=0000", bus.O); else passed++;
      bus.prog_en = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL rst60_done got=%b exp=0", bus.cfg_done); else passed++;
      shift_bits(frame_a, CFG);
      tick();
      bus.I = 12'h00F; #1;
      total++; if (bus.cfg_done !== 1'b1) $display("FAIL rst60_reload got=%b exp=1", bus.cfg_done); else passed++;
      total++; if (bus.O !== 4'b0001) $display("FAIL rst60_o_after got=%b exp=0001", bus.O); else passed++;
   endtask

`ifdef CLB_CFG_PARITY_EN
   task automatic test_parity();
      logic [147:0] bad;
      bad = frame_a;
      bad[CFG-1] = ~bad[CFG-1];
      bus.I = 12'h00F;
      shift_bits(bad, CFG);
      tick();
      total++; if (bus.cfg_err !== 1'b1) $display("FAIL par_err got=%b exp=1", bus.cfg_err); else passed++;
      total++; if (bus.cfg_done !== 1'b0) $display("FAIL par_done got=%b exp=0", bus.cfg_done); else passed++;
      total++; if (bus.O !== 4'b0) $display("FAIL par_o got=%b exp=0000", bus.O); else passed++;
      shift_bits(frame_a, CFG);
      tick();
      total++; if (bus.cfg_err !== 1'b0) $display("FAIL par_clr got=%b exp=0", bus.cfg_err); else passed++;
      total++; if (bus.cfg_done !== 1'b1) $display("FAIL par_good got=%b exp=1", bus.cfg_done); else passed++;
      total++; if (bus.O !== 4'b0001) $display("FAIL par_good_o got=%b exp=0001", bus.O); else passed++;
   endtask
`else
   task automatic test_err_tied();
      total++; if (bus.cfg_err !== 1'b0) $display("FAIL err_tied got=%b exp=0", bus.cfg_err); else passed++;
   endtask
`endif

   initial begin
      frame_a = mk_frame(B_AND4, B_IDLE, B_IDLE, B_IDLE);
      frame_b = mk_frame(B_AND4, B_TOG, B_IDLE, B_IDLE);
      test_reset();
      test_comb_lut();
      test_reg_toggle();
      test_reset_mid();
      test_partial();
      test_passthrough();
      test_reset_shift60();
`ifdef CLB_CFG_PARITY_EN
      test_parity();
`else
      test_err_tied();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
